// File: rtl/memory_mapper.sv
// memory_mapper
// ---------------------------------------------------------------------------
// Page-based address translator for the 6502 system bus. Sixteen 12-bit
// page-mapping registers, one per 4 KiB CPU page, replace the CPU's top
// address nibble with a 12-bit physical page number when translation is
// enabled, giving a 24-bit physical address {MO, cpu_addr[11:0]}.
//
// Ports:
//   clk       in   1   bus clock, all state changes on the rising edge
//   rst_n     in   1   synchronous active-low reset
//   cs        in   1   mapping register file select
//   MM_cs     in   1   control select (enable bit)
//   rw        in   1   1 = read, 0 = write
//   RS        in   4   mapping register index
//   data_in   in  12   write data
//   data_out  out 12   read data (zero unless readback is compiled in)
//   MA        in   4   CPU address bits [15:12]
//   MO        out 12   physical address bits [23:12]
//
// Optional feature macro: MM_READBACK_EN
//   defined   -> registers and enable bit can be read back on data_out
//   undefined -> data_out is tied to zero and the read mux is not built
// ---------------------------------------------------------------------------
module memory_mapper (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        MM_cs,
    input  logic        rw,
    input  logic [3:0]  RS,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    input  logic [3:0]  MA,
    output logic [11:0] MO
);

    logic [11:0] map_q [16];
    logic [11:0] map_d [16];
    logic        enable_q;
    logic        enable_d;

    // Next-state for the register file and enable bit. A combined cs/MM_cs
    // write updates both in the same edge; only the addressed map entry
    // changes.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            map_d[i] = map_q[i];
        end
        enable_d = enable_q;
        if (cs && !rw) begin
            map_d[RS] = data_in;
        end
        if (MM_cs && !rw) begin
            enable_d = data_in[0];
        end
    end

    // Reset loads an identity map so that turning translation on right
    // after reset does not move any page. Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                map_q[i] <= {8'h00, 4'(i)};
            end
            enable_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                map_q[i] <= map_d[i];
            end
            enable_q <= enable_d;
        end
    end

    // Translation is a pure mux of registered state, no latency from MA.
    always_comb begin
        if (enable_q) begin
            MO = map_q[MA];
        end else begin
            MO = {8'h00, MA};
        end
    end

`ifdef MM_READBACK_EN
    // Register select takes priority over the control select on reads.
    always_comb begin
        data_out = 12'h000;
        if (cs && rw) begin
            data_out = map_q[RS];
        end else if (MM_cs && rw) begin
            data_out = {11'b0, enable_q};
        end
    end
`else
    assign data_out = 12'h000;
`endif

endmodule

// File: tb/tb_memory_mapper.sv
// tb_memory_mapper
// ---------------------------------------------------------------------------
// Directed testbench for memory_mapper: a table of hand-computed vectors
// plus short hand-written sequences for reset and multi-cycle corner cases.
// Readback expectations collapse to zero when MM_READBACK_EN is undefined.
// ---------------------------------------------------------------------------
module tb_memory_mapper;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        MM_cs;
    logic        rw;
    logic [3:0]  RS;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic [3:0]  MA;
    logic [11:0] MO;

    int checks;
    int errors;

    memory_mapper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .MM_cs    (MM_cs),
        .rw       (rw),
        .RS       (RS),
        .data_in  (data_in),
        .data_out (data_out),
        .MA       (MA),
        .MO       (MO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        doClock;
        logic        cs;
        logic        mmCs;
        logic        rw;
        logic [3:0]  rs;
        logic [11:0] din;
        logic [3:0]  ma;
        logic [11:0] expMo;
        logic [11:0] expRead;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] readExp(input logic [11:0] v);
`ifdef MM_READBACK_EN
        return v;
`else
        return 12'h000 & v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] actual,
                               input logic [23:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge, optionally cross one rising edge,
    // then settle 1 time unit before sampling.
    task automatic applyStimulus(input logic doClock, input logic csV,
                                 input logic mmCsV, input logic rwV,
                                 input logic [3:0] rsV, input logic [11:0] dinV,
                                 input logic [3:0] maV);
        @(negedge clk);
        cs      = csV;
        MM_cs   = mmCsV;
        rw      = rwV;
        RS      = rsV;
        data_in = dinV;
        MA      = maV;
        if (doClock) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic idle(input logic [3:0] maV);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 12'h000, maV);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        cs      = 1'b0;
        MM_cs   = 1'b0;
        rw      = 1'b1;
        RS      = 4'h0;
        data_in = 12'h000;
        MA      = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state: passthrough, physical address of cpu 0x0abc
        idle(4'h0);
        checkOutput("reset_phys", {MO, 12'habc}, 24'h000abc);
        checkOutput("reset_dout", {12'h0, data_out}, 24'h0);
        for (int i = 0; i < 16; i++) begin
            idle(4'(i));
            checkOutput($sformatf("reset_pass_%0d", i), {12'h0, MO}, {20'h0, 4'(i)});
        end

        // Enable straight out of reset: identity contents
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h001, 4'h0);
        for (int i = 0; i < 16; i++) begin
            idle(4'(i));
            checkOutput($sformatf("ident_%0d", i), {12'h0, MO}, {20'h0, 4'(i)});
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 4'h0);

        vecs.push_back('{"wr_map0_disabled", 1, 1, 0, 0, 4'h0, 12'h0cc, 4'h0, 12'h000, 12'h000});
        vecs.push_back('{"enable_on",        1, 0, 1, 0, 4'h0, 12'h001, 4'h0, 12'h0cc, 12'h000});
        vecs.push_back('{"ma1_identity",     0, 0, 0, 1, 4'h0, 12'h000, 4'h1, 12'h001, 12'h000});
        vecs.push_back('{"maF_identity",     0, 0, 0, 1, 4'h0, 12'h000, 4'hf, 12'h00f, 12'h000});
        vecs.push_back('{"wr_map5_live",     1, 1, 0, 0, 4'h5, 12'h9a7, 4'h5, 12'h9a7, 12'h000});
        vecs.push_back('{"rd_map5",          0, 1, 0, 1, 4'h5, 12'h000, 4'h5, 12'h9a7, 12'h9a7});
        vecs.push_back('{"rd_enable",        0, 0, 1, 1, 4'h0, 12'h000, 4'h5, 12'h9a7, 12'h001});
        vecs.push_back('{"rd_cs_priority",   0, 1, 1, 1, 4'h0, 12'h000, 4'h0, 12'h0cc, 12'h0cc});
        vecs.push_back('{"enable_off",       1, 0, 1, 0, 4'h0, 12'h000, 4'h0, 12'h000, 12'h000});
        vecs.push_back('{"rd_enable_off",    0, 0, 1, 1, 4'h0, 12'h000, 4'h5, 12'h005, 12'h000});
        vecs.push_back('{"rd_map0_kept",     0, 1, 0, 1, 4'h0, 12'h000, 4'h0, 12'h000, 12'h0cc});
        vecs.push_back('{"rd_map1_untouched",0, 1, 0, 1, 4'h1, 12'h000, 4'h1, 12'h001, 12'h001});
        vecs.push_back('{"wr_both",          1, 1, 1, 0, 4'h2, 12'h041, 4'h2, 12'h041, 12'h000});
        vecs.push_back('{"rd_map2",          0, 1, 0, 1, 4'h2, 12'h000, 4'h2, 12'h041, 12'h041});
        vecs.push_back('{"ctrl_bit0_only_0", 1, 0, 1, 0, 4'h0, 12'hffe, 4'h2, 12'h002, 12'h000});
        vecs.push_back('{"ctrl_bit0_only_1", 1, 0, 1, 0, 4'h0, 12'hf01, 4'h2, 12'h041, 12'h000});
        vecs.push_back('{"no_select_zero",   0, 0, 0, 1, 4'h2, 12'h000, 4'h0, 12'h0cc, 12'h000});

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].doClock, vecs[k].cs, vecs[k].mmCs, vecs[k].rw,
                          vecs[k].rs, vecs[k].din, vecs[k].ma);
            checkOutput({vecs[k].name, "_MO"}, {12'h0, MO}, {12'h0, vecs[k].expMo});
            checkOutput({vecs[k].name, "_dout"}, {12'h0, data_out},
                        {12'h0, readExp(vecs[k].expRead)});
        end

        // Physical address with map[0]=0cc enabled, then disabled
        idle(4'h0);
        checkOutput("phys_enabled", {MO, 12'habc}, 24'h0ccabc);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h000, 4'h0);
        checkOutput("phys_disabled", {MO, 12'habc}, 24'h000abc);

        // Mid-run reset with enable=1 and map[3]=fff, reset beats a write
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 12'hfff, 4'h3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h001, 4'h3);
        checkOutput("pre_reset_map3", {12'h0, MO}, 24'h000fff);
        @(negedge clk);
        rst_n   = 1'b0;
        cs      = 1'b1;
        MM_cs   = 1'b1;
        rw      = 1'b0;
        RS      = 4'h3;
        data_in = 12'h5a1;
        MA      = 4'h3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4'h3);
        checkOutput("post_reset_ma3", {12'h0, MO}, 24'h000003);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 12'h000, 4'h3);
        checkOutput("post_reset_enable", {12'h0, data_out}, 24'h000000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 12'h001, 4'h3);
        checkOutput("post_reset_map3_enabled", {12'h0, MO}, 24'h000003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
